// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle restoring divider, one quotient bit per clock.
// Start/done handshake; results are registered and hold until the next done or rst.
// Optional macro SEQ_DIV_SIGNED_EN: two's-complement operands (magnitude divide plus
// sign fix-up on entry to FIN). Without it only unsigned logic is built.
module seq_div_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend shift reg; quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;    // captured divisor (magnitude)
    logic [WIDTH-1:0] prem_q, prem_d;  // partial remainder, always < divisor after restore
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;         // WIDTH+1-bit partial remainder after the shift
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] prem_step;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    // One shift-and-subtract iteration plus operand magnitudes and final fix-up.
    always_comb begin
        shifted   = {prem_q, dvd_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};
        qbit      = ~trial[WIDTH];
        prem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_step  = {dvd_q[WIDTH-2:0], qbit};
`ifdef SEQ_DIV_SIGNED_EN
        // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
        mag_a     = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        mag_b     = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        fin_q     = neg_quo_q ? (~dvd_step + 1'b1) : dvd_step;
        fin_r     = neg_rem_q ? (~prem_step + 1'b1) : prem_step;
`else
        mag_a     = dividend;
        mag_b     = divisor;
        fin_q     = dvd_step;
        fin_r     = prem_step;
`endif
    end

    // Next-state and registered-output logic for the IDLE/RUN/FIN sequencer.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (start) begin
                    if (divisor == '0) begin
                        // Zero divisor skips RUN and reports immediately.
                        state_d = StFin;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        dvd_d   = mag_a;
                        dvs_d   = mag_b;
                        prem_d  = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
                        neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d = dividend[WIDTH-1];
`endif
                    end
                end
            end
            StRun: begin
                busy_d = 1'b1;
                dvd_d  = dvd_step;
                prem_d = prem_step;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = fin_q;
                    rem_d   = fin_r;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: scoreboard of expected results, popped on done.
module tb_seq_div_unit;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t drop_e;

    seq_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model, independent of the shift/subtract structure.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
`ifdef SEQ_DIV_SIGNED_EN
        int sa;
        int sb_v;
`endif
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa   = int'($signed(a));
            sb_v = int'($signed(b));
            e.q  = W'(sa / sb_v);
            e.r  = W'(sa % sb_v);
`else
            e.q  = a / b;
            e.r  = a % b;
`endif
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("quotient", quotient, mon_e.q);
                check_eq("remainder", remainder, mon_e.r);
                check_eq("div_by_zero", div_by_zero, mon_e.dbz);
            end
        end
    end

    // Drive one start pulse; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    // Count busy cycles and locate done relative to the accepting edge.
    task automatic watch(input string tag, input int lat, input int exp_busy);
        int busy_n  = 0;
        int done_at = 0;
        for (int n = 1; n <= lat + 2; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1 && done_at == 0) done_at = n;
        end
        check_eq({tag, "_done_cycle"}, done_at, lat);
        check_eq({tag, "_busy_cycles"}, busy_n, exp_busy);
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        if (b == '0) watch(tag, 1, 0);
        else         watch(tag, W + 1, W);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_quotient"}, quotient, 0);
        check_eq({tag, "_remainder"}, remainder, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_dbz"}, div_by_zero, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        op("basic_13_3", 4'd13, 4'd3);
        op("edge_15_1", 4'd15, 4'd1);
        op("edge_2_9", 4'd2, 4'd9);
        op("edge_0_5", 4'd0, 4'd5);
        op("dbz_7_0", 4'd7, 4'd0);
        op("after_dbz_9_4", 4'd9, 4'd4);

        // start during RUN must be ignored
        launch(4'd13, 4'd3);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        @(negedge clk);
        start    = 1'b0;
        repeat (W - 1) @(negedge clk);
        check_eq("ignored_start_done", done, 1);
        repeat (W + 3) @(negedge clk);

        // start in the FIN cycle is accepted back-to-back
        launch(4'd13, 4'd3);
        repeat (W) @(negedge clk);
        @(negedge clk);
        check_eq("b2b_first_done", done, 1);
        sb.push_back(model(4'd9, 4'd2));
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch("b2b_second", W + 1, W);

        // reset mid-RUN: no done, outputs cleared
        launch(4'd13, 4'd3);
        drop_e = sb.pop_back();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        divisor = 4'd1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check_cleared("mid_reset");
        repeat (W + 3) @(negedge clk);
        op("post_reset_10_3", 4'd10, 4'd3);

`ifdef SEQ_DIV_SIGNED_EN
        op("signed_m7_2", 4'b1001, 4'd2);
        op("signed_7_m2", 4'd7, 4'b1110);
        op("signed_m8_m1", 4'b1000, 4'b1111);
        op("signed_dbz_m3_0", 4'b1101, 4'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            op("random", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
